// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: operand-mux select codes and the in-flight
// instruction record used by the forwarding controller.
package pipe_pkg;

  localparam int REG_NUM_W = 5;

  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF    = 2'b00;
  localparam fwd_sel_t FWD_EXMEM = 2'b01;
  localparam fwd_sel_t FWD_MEMWB = 2'b10;
  localparam fwd_sel_t FWD_WBRET = 2'b11;

  typedef struct packed {
    logic                 valid;
    logic [REG_NUM_W-1:0] dst;
    logic                 regwrite;
    logic                 memread;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // True when the slot will deliver a value for register r ($0 never does).
  function automatic logic slot_produces(slot_t s, logic [REG_NUM_W-1:0] r);
    return s.valid && s.regwrite && (s.dst == r) && (r != '0);
  endfunction

endpackage

// File: rtl/fwd_pick.sv
// Combinational nearest-producer select for one ALU operand.
module fwd_pick
  import pipe_pkg::*;
(
  input  logic                 use_src,
  input  logic [REG_NUM_W-1:0] src,
  input  slot_t                s_ex,
  input  slot_t                s_mem,
  input  slot_t                s_wb,
  output fwd_sel_t             sel
);

  always_comb begin
    sel = FWD_RF;
    if (!use_src || src == '0) begin
      sel = FWD_RF;
    end else if (slot_produces(s_ex, src)) begin
      sel = FWD_EXMEM;
    end else if (slot_produces(s_mem, src)) begin
      sel = FWD_MEMWB;
    end else if (slot_produces(s_wb, src)) begin
      sel = FWD_WBRET;
    end
  end

endmodule

// File: rtl/ex_fwd_ctrl.sv
// EX-stage operand forwarding controller: tracks destinations in EX/MEM/WB,
// registers per-operand mux selects and raises the load-use stall.
module ex_fwd_ctrl
  import pipe_pkg::*;
#(
  parameter int REG_W = REG_NUM_W,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_regwrite,
  input  logic             id_memread,
  input  logic             flush,
  output logic             stall,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic [CNT_W-1:0] stall_cnt
);

  slot_t    slot_p0;
  slot_t    slot_p1;
  slot_t    slot_p2;
  slot_t    id_slot;
  fwd_sel_t sel_a;
  fwd_sel_t sel_b;
  logic     load_hazard;
  logic     enter_ex;

  fwd_pick u_pick_a (
    .use_src (id_use_rs),
    .src     (id_rs),
    .s_ex    (slot_p0),
    .s_mem   (slot_p1),
    .s_wb    (slot_p2),
    .sel     (sel_a)
  );

  fwd_pick u_pick_b (
    .use_src (id_use_rt),
    .src     (id_rt),
    .s_ex    (slot_p0),
    .s_mem   (slot_p1),
    .s_wb    (slot_p2),
    .sel     (sel_b)
  );

  // A load in EX cannot forward yet; the dependent instruction must wait a cycle.
  always_comb begin
    load_hazard = id_valid && slot_p0.memread &&
                  ((id_use_rs && slot_produces(slot_p0, id_rs)) ||
                   (id_use_rt && slot_produces(slot_p0, id_rt)));
    stall       = load_hazard && !flush;
    enter_ex    = id_valid && !stall && !flush;
  end

  always_comb begin
    id_slot          = SLOT_BUBBLE;
    id_slot.valid    = 1'b1;
    id_slot.dst      = id_dst;
    id_slot.regwrite = id_regwrite;
    id_slot.memread  = id_memread;
  end

  // ID -> EX boundary; EX -> MEM -> WB tracking shift.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      slot_p0   <= SLOT_BUBBLE;
      slot_p1   <= SLOT_BUBBLE;
      slot_p2   <= SLOT_BUBBLE;
      fwd_a_sel <= FWD_RF;
      fwd_b_sel <= FWD_RF;
    end else begin
      slot_p2   <= slot_p1;
      slot_p1   <= slot_p0;
      slot_p0   <= enter_ex ? id_slot : SLOT_BUBBLE;
      fwd_a_sel <= enter_ex ? sel_a : FWD_RF;
      fwd_b_sel <= enter_ex ? sel_b : FWD_RF;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Directed-vector bench for ex_fwd_ctrl with hand-computed selects and stalls.
module tb_ex_fwd_ctrl;
  import pipe_pkg::*;

  logic        Clk;
  logic        Reset;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic [4:0]  id_dst;
  logic        id_regwrite;
  logic        id_memread;
  logic        flush;
  logic        stall;
  logic [1:0]  fwd_a_sel;
  logic [1:0]  fwd_b_sel;
  logic [15:0] stall_cnt;

  int vectors;
  int miscompares;

  ex_fwd_ctrl #(.REG_W(5), .CNT_W(16)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (id_use_rs),
    .id_use_rt   (id_use_rt),
    .id_dst      (id_dst),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .flush       (flush),
    .stall       (stall),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall_cnt   (stall_cnt)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dst,
                       input logic rw, input logic mr, input logic fl);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_use_rs   = urs;
    id_use_rt   = urt;
    id_dst      = dst;
    id_regwrite = rw;
    id_memread  = mr;
    flush       = fl;
  endtask

  task automatic alu(input logic [4:0] dst, input logic [4:0] rs, input logic [4:0] rt);
    issue(1'b1, rs, rt, 1'b1, 1'b1, dst, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic lw(input logic [4:0] dst, input logic [4:0] rs);
    issue(1'b1, rs, 5'd0, 1'b1, 1'b0, dst, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic nop();
    issue(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 3; i++) begin
      nop();
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset       = 1'b0;
    nop();
    #2;
    chk("rst_a", fwd_a_sel, 2'b00);
    chk("rst_b", fwd_b_sel, 2'b00);
    chk("rst_stall", stall, 1'b0);
    chk("rst_cnt", stall_cnt, 16'd0);
    #6 Reset = 1'b1;
    tick();

    // add $3 ; sub $4,$3,$5
    alu(5'd3, 5'd1, 5'd2);
    tick();
    alu(5'd4, 5'd3, 5'd5);
    #1 chk("b2b_stall", stall, 1'b0);
    tick();
    chk("b2b_a", fwd_a_sel, 2'b01);
    chk("b2b_b", fwd_b_sel, 2'b00);
    drain();
    chk("drain_a", fwd_a_sel, 2'b00);

    // distance 2
    alu(5'd7, 5'd1, 5'd2);  tick();
    alu(5'd10, 5'd1, 5'd2); tick();
    alu(5'd11, 5'd1, 5'd7); tick();
    chk("d2_b", fwd_b_sel, 2'b10);
    chk("d2_a", fwd_a_sel, 2'b00);
    drain();

    // distance 3
    alu(5'd7, 5'd1, 5'd2);  tick();
    alu(5'd10, 5'd1, 5'd2); tick();
    alu(5'd11, 5'd1, 5'd2); tick();
    alu(5'd12, 5'd2, 5'd7); tick();
    chk("d3_b", fwd_b_sel, 2'b11);
    chk("d3_a", fwd_a_sel, 2'b00);
    drain();

    // load-use: lw $8 ; add $9,$8,$8
    lw(5'd8, 5'd1); tick();
    alu(5'd9, 5'd8, 5'd8);
    #1 chk("lu_stall", stall, 1'b1);
    tick();
    chk("lu_bub_a", fwd_a_sel, 2'b00);
    chk("lu_bub_b", fwd_b_sel, 2'b00);
    #1 chk("lu_stall_clr", stall, 1'b0);
    tick();
    chk("lu_a", fwd_a_sel, 2'b10);
    chk("lu_b", fwd_b_sel, 2'b10);
    chk("lu_cnt", stall_cnt, 16'd1);
    drain();

    // writes to $0 never forward or stall
    lw(5'd0, 5'd1); tick();
    alu(5'd5, 5'd0, 5'd0);
    #1 chk("z_stall", stall, 1'b0);
    tick();
    chk("z_a", fwd_a_sel, 2'b00);
    chk("z_b", fwd_b_sel, 2'b00);
    drain();

    // nearest of two writers of $6 wins; then operands from different slots
    alu(5'd6, 5'd1, 5'd2);  tick();
    alu(5'd6, 5'd1, 5'd2);  tick();
    alu(5'd13, 5'd6, 5'd6); tick();
    chk("pri_a", fwd_a_sel, 2'b01);
    chk("pri_b", fwd_b_sel, 2'b01);
    alu(5'd15, 5'd6, 5'd13); tick();
    chk("mix_a", fwd_a_sel, 2'b10);
    chk("mix_b", fwd_b_sel, 2'b01);
    drain();

    // unused operand never forwards
    alu(5'd20, 5'd1, 5'd2); tick();
    issue(1'b1, 5'd20, 5'd20, 1'b0, 1'b1, 5'd21, 1'b1, 1'b0, 1'b0);
    tick();
    chk("unused_a", fwd_a_sel, 2'b00);
    chk("used_b", fwd_b_sel, 2'b01);
    drain();

    // flush during load-use hazard
    lw(5'd8, 5'd1); tick();
    issue(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
    #1 chk("fl_stall", stall, 1'b0);
    tick();
    chk("fl_a", fwd_a_sel, 2'b00);
    chk("fl_b", fwd_b_sel, 2'b00);
    chk("fl_cnt", stall_cnt, 16'd1);
    drain();

    // asynchronous reset with live hazard
    alu(5'd21, 5'd1, 5'd2); tick();
    lw(5'd22, 5'd21);       tick();
    chk("pre_a", fwd_a_sel, 2'b01);
    alu(5'd23, 5'd22, 5'd21);
    #1 chk("pre_stall", stall, 1'b1);
    Reset = 1'b0;
    #1;
    chk("ar_a", fwd_a_sel, 2'b00);
    chk("ar_stall", stall, 1'b0);
    chk("ar_cnt", stall_cnt, 16'd0);
    #1 Reset = 1'b1;
    alu(5'd24, 5'd21, 5'd22);
    tick();
    chk("post_a", fwd_a_sel, 2'b00);
    chk("post_b", fwd_b_sel, 2'b00);
    chk("post_cnt", stall_cnt, 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ex_fwd_ctrl.md
# ex_fwd_ctrl

Operand-forwarding controller for the 5-stage pipeline. It produces the registered 2-bit select codes that drive the two 32-bit 4:1 operand muxes at the EX-stage ALU inputs, one for operand A and one for operand B. It also raises the load-use stall.

It sits between decode and the ID/EX boundary. Internally it tracks the destination register of every instruction in EX, MEM and WB, so forwarding decisions need no feedback from later stages.

## Interface
Parameters:
- REG_W, 5, register-number width
- CNT_W, 16, stall-counter width

Ports:
- Clk  in  1  pipeline clock, rising edge
- Reset  in  1  asynchronous, active-low; clears all state
- id_valid  in  1  instruction in ID is real (not a bubble)
- id_rs  in  REG_W  source A register number
- id_rt  in  REG_W  source B register number
- id_use_rs  in  1  instruction reads rs
- id_use_rt  in  1  instruction reads rt
- id_dst  in  REG_W  destination register (post RegDst select)
- id_regwrite  in  1  instruction writes id_dst
- id_memread  in  1  instruction is a load
- flush  in  1  squash the instruction leaving ID (branch taken)
- stall  out  1  hold PC and IF/ID; combinational
- fwd_a_sel  out  2  operand A mux select, registered, valid during EX
- fwd_b_sel  out  2  operand B mux select, registered, valid during EX
- stall_cnt  out  CNT_W  saturating count of stall cycles

## Operation
Select encoding, shared with both operand muxes:
- 00: register-file value from ID/EX
- 01: EX/MEM ALU result (producer one stage ahead)
- 10: MEM/WB write-back value (producer two ahead)
- 11: WB/retire holding register (producer three ahead; covers register-file write-after-read)

Tracking state:
- Three slots, S_EX, S_MEM and S_WB, each holding {valid, dst, regwrite, memread}.
- Each rising edge shifts S_WB←S_MEM, S_MEM←S_EX, S_EX←the ID instruction.
- S_EX instead loads a bubble (valid=0) when id_valid=0, stall=1 or flush=1.

A slot "produces r" when valid && regwrite && dst==r && r!=0.

Stall:
- stall = id_valid && S_EX.valid && S_EX.memread && S_EX.regwrite && S_EX.dst!=0 && ((id_use_rs && S_EX.dst==id_rs) || (id_use_rt && S_EX.dst==id_rt)).
- flush overrides stall (stall forced 0).

Select computation, per operand with source r (rs for A, rt for B):
- If the operand is unused, or r==0: 00.
- Else if S_EX produces r: 01.
- Else if S_MEM produces r: 10.
- Else if S_WB produces r: 11.
- Else: 00.
- Nearest producer always wins.
- The computed value is registered into fwd_x_sel on the same edge the instruction enters S_EX.
- If a bubble enters S_EX, fwd_x_sel registers 00.

stall_cnt increments on each edge where stall=1. It saturates at all-ones.

## Timing
- Reset asserted, asynchronously: all slots invalid, fwd_a_sel=fwd_b_sel=00, stall_cnt=0. stall reads 0 because slots are empty.
- Decision latency: one edge. Sources are sampled in ID at cycle t; the selects are valid throughout cycle t+1, when the instruction is in EX.
- A load followed immediately by a dependent instruction costs exactly 1 stall cycle. On the next cycle the load is in S_MEM and the select becomes 10.
- stall and flush in the same cycle: flush wins; a bubble enters and there is no stall.
- Reset deasserted mid-stream: the first instruction after reset sees empty slots and gets selects 00.
- Both operands may match different slots independently; rs==rt gives identical selects.

## Structure
- Shared package pipe_pkg holds the select constants FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10, FWD_WBRET=2'b11. The operand-mux instantiation site uses the same constants.
- pipe_pkg also holds the slot record layout {valid, dst, regwrite, memread}.
- One natural sub-module: fwd_pick, a combinational priority select. It takes one source register and three slots and returns a 2-bit select. It is instantiated twice, once per operand.

## Test plan
- Back-to-back ALU dependency: add $3 then sub $4,$3,$5 → sub in EX has fwd_a_sel=01, fwd_b_sel=00, stall never asserted.
- Distance 2 and 3: producer of $7, then 1 or 2 independent instructions, then consumer of $7 on rt → fwd_b_sel=10 and 11 respectively.
- Load-use: lw $8 then add $9,$8,$8 → stall=1 for exactly one cycle, bubble in EX with selects 00; add then enters EX with fwd_a_sel=fwd_b_sel=10; stall_cnt=1.
- $zero and priority: writes to $0 never forward (select 00). Two in-flight writers of $6 at distances 1 and 2 → select 01.
- Flush during a load-use hazard: stall=0, next EX selects 00, stall_cnt unchanged.
- Reset asserted mid-stream with live hazards → outputs 00/0 immediately without a clock edge. After release, the first consumer sees 00.
